// File: rtl/ifmap_load_ctrl.sv
// Sequencer feeding the ifmap slicing FIFO from DRAM and draining it into the row RF.
// Keeps one DRAM read in flight at most; abort drains that read before clearing the FIFO.
module ifmap_load_ctrl #(
  parameter int READS_PER_FRAME = 122,
  parameter int ADDR_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [2:0]        mode,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [10:0]       num_words,
  output logic              dram_req,
  output logic [ADDR_W-1:0] dram_addr,
  input  logic              dram_gnt,
  input  logic              dram_rvalid,
  output logic [2:0]        fifo_mode,
  output logic              fifo_clear,
  output logic              fifo_en,
  output logic              fifo_need_read,
  input  logic              fifo_can_write,
  input  logic              fifo_can_read,
  input  logic [4:0]        fifo_read_count,
  input  logic              rf_ready,
  output logic              rf_we,
  output logic              row_done,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int RW = $clog2(READS_PER_FRAME + 1);
  localparam logic [RW-1:0] RPF = RW'(READS_PER_FRAME);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        mode_q, mode_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [10:0]       num_q, num_d;
  logic [10:0]       fetched_q, fetched_d;
  logic [RW-1:0]     reads_q, reads_d;
  logic              outst_q, outst_d;
  logic              req_q, req_d;
  logic              rf_we_q, rf_we_d;
  logic              row_q, row_d;
  logic              row_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      mode_q    <= '0;
      base_q    <= '0;
      num_q     <= '0;
      fetched_q <= '0;
      reads_q   <= '0;
      outst_q   <= 1'b0;
      req_q     <= 1'b0;
      rf_we_q   <= 1'b0;
      row_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      base_q    <= base_d;
      num_q     <= num_d;
      fetched_q <= fetched_d;
      reads_q   <= reads_d;
      outst_q   <= outst_d;
      req_q     <= req_d;
      rf_we_q   <= rf_we_d;
      row_q     <= row_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    base_d    = base_q;
    num_d     = num_q;
    fetched_d = fetched_q;
    reads_d   = reads_q;
    outst_d   = outst_q;
    fifo_clear = 1'b0;
    done       = 1'b0;
    err        = 1'b0;

    busy      = (state_q != IDLE);
    fifo_mode = mode_q;
    rf_we     = rf_we_q;
    row_done  = row_q;
    dram_addr = base_q + ADDR_W'(fetched_q);

    // req_q keeps a not-yet-granted request up even if can_write drops
    dram_req = 1'b0;
    if (state_q == RUN)
      dram_req = req_q
               | (!outst_q && (fetched_q < num_q) && fifo_can_write);
    else if (state_q == FLUSH)
      dram_req = req_q;
    req_d = dram_req && !dram_gnt;

    fifo_en = (state_q == RUN) && dram_rvalid && outst_q;
    fifo_need_read = (state_q == RUN) && fifo_can_read && rf_ready
                   && !fifo_en && (reads_q < RPF);

    row_hit = ((mode_q == 3'd0) && (fifo_read_count == 5'd16))
            || ((mode_q == 3'd1) && (fifo_read_count == 5'd8));
    rf_we_d = fifo_need_read;
    row_d   = fifo_need_read && row_hit;
    if (fifo_need_read)
      reads_d = reads_q + 1'b1;

    if (dram_req && dram_gnt) begin
      outst_d   = 1'b1;
      fetched_d = fetched_q + 1'b1;
    end else if (dram_rvalid && outst_q) begin
      outst_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (mode > 3'd1) begin
            err = 1'b1;
          end else begin
            mode_d     = mode;
            base_d     = base_addr;
            num_d      = num_words;
            fetched_d  = '0;
            reads_d    = '0;
            outst_d    = 1'b0;
            req_d      = 1'b0;
            fifo_clear = 1'b1;
            state_d    = RUN;
          end
        end
      end
      RUN: begin
        if (abort) begin
          if (outst_q || dram_req) begin
            state_d = FLUSH;
          end else begin
            fifo_clear = 1'b1;
            state_d    = IDLE;
          end
        end else if (rf_we_q && (reads_q == RPF)) begin
          state_d = DONE;
        end
      end
      FLUSH: begin
        if ((outst_q && dram_rvalid) || (!outst_q && !req_q)) begin
          fifo_clear = 1'b1;
          outst_d    = 1'b0;
          req_d      = 1'b0;
          state_d    = IDLE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ifmap_load_ctrl.sv
// Directed bench for ifmap_load_ctrl: a per-cycle vector table plus
// full-frame, abort/flush, address-wrap and async-reset sequences.
module tb_ifmap_load_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, abort;
  logic [2:0]  mode;
  logic [15:0] base_addr;
  logic [10:0] num_words;
  logic        dram_req;
  logic [15:0] dram_addr;
  logic        dram_gnt, dram_rvalid;
  logic [2:0]  fifo_mode;
  logic        fifo_clear, fifo_en, fifo_need_read;
  logic        fifo_can_write, fifo_can_read;
  logic [4:0]  fifo_read_count;
  logic        rf_ready, rf_we, row_done, busy, done, err;
  logic [8:0]  outs;

  always #5 clk = ~clk;

  assign outs = {dram_req, fifo_clear, fifo_en, fifo_need_read,
                 rf_we, row_done, busy, done, err};

  ifmap_load_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
    .base_addr(base_addr), .num_words(num_words),
    .dram_req(dram_req), .dram_addr(dram_addr), .dram_gnt(dram_gnt),
    .dram_rvalid(dram_rvalid), .fifo_mode(fifo_mode),
    .fifo_clear(fifo_clear), .fifo_en(fifo_en),
    .fifo_need_read(fifo_need_read), .fifo_can_write(fifo_can_write),
    .fifo_can_read(fifo_can_read), .fifo_read_count(fifo_read_count),
    .rf_ready(rf_ready), .rf_we(rf_we), .row_done(row_done),
    .busy(busy), .done(done), .err(err)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        st;
    logic        ab;
    logic [2:0]  md;
    logic        gnt;
    logic        rv;
    logic        cw;
    logic        cr;
    logic        rdy;
    logic [4:0]  cnt;
    logic [8:0]  exp;
    logic [15:0] addr;
  } vec_t;

  vec_t tbl[14];

  task automatic idle_inputs();
    start = 0; abort = 0; mode = 0; dram_gnt = 0; dram_rvalid = 0;
    fifo_can_write = 0; fifo_can_read = 0; rf_ready = 0;
    fifo_read_count = 0;
  endtask

  task automatic run_frame(input logic [2:0] m, input logic [15:0] base,
                           input int num, input bit tog, input bit rnd);
    int reqs = 0, addr_bad = 0, we_n = 0, rows = 0, viol = 0;
    int credits = 0, writes = 0, strobes = 0, cyc = 0;
    int last_we = -10, done_cyc = -1, wait_c = 0;
    bit pend = 0;
    logic [15:0] nexp = base;
    @(negedge clk);
    start = 1; mode = m; base_addr = base; num_words = 11'(num);
    fifo_can_write = 1;
    @(negedge clk);
    start = 0;
    while (done_cyc < 0 && cyc < 6000) begin
      dram_gnt = 0;
      rf_ready = tog ? ((cyc / 3) % 2 == 0) : 1'b1;
      fifo_can_read = (credits > 0);
      fifo_read_count = 5'((strobes % ((m == 0) ? 16 : 8)) + 1);
      dram_rvalid = 0;
      if (pend) begin
        if (wait_c == 1) begin
          dram_rvalid = 1; pend = 0;
        end else wait_c--;
      end
      #1;
      dram_gnt = dram_req;
      #1;
      if (dram_req) begin
        reqs++;
        if (dram_addr !== nexp) addr_bad++;
        nexp = nexp + 16'd1;
        pend = 1;
        wait_c = rnd ? int'($urandom_range(1, 8)) : 1;
      end
      if (fifo_en) begin
        credits++; writes++;
        if (writes == num) credits += 122 - num;
      end
      if (fifo_need_read) begin
        credits--; strobes++;
        if (!rf_ready || fifo_en) viol++;
      end
      if (rf_we) begin we_n++; last_we = cyc; end
      if (row_done) rows++;
      if (done) done_cyc = cyc;
      cyc++;
      @(negedge clk);
    end
    dram_gnt = 0; dram_rvalid = 0; fifo_can_read = 0;
    #1;
    chk("frame_done_seen", done_cyc >= 0, 1);
    chk("frame_req_count", reqs, num);
    chk("frame_addr_errs", addr_bad, 0);
    chk("frame_rf_we_count", we_n, 122);
    chk("frame_row_done_count", rows, (m == 0) ? 7 : 15);
    chk("frame_done_latency", done_cyc - last_we, 1);
    chk("frame_read_violations", viol, 0);
    chk("frame_busy_after", busy, 0);
  endtask

  initial begin
    rst = 1; base_addr = 16'h0010; num_words = 11'd1;
    idle_inputs();
    repeat (2) @(negedge clk);
    #1;
    chk("reset_outs", outs, 9'b0);
    chk("reset_fifo_mode", fifo_mode, 3'd0);
    rst = 0;

    //         st ab md gnt rv cw cr rdy cnt  exp(req clr en need we row busy done err)
    tbl[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 5'd0,  9'b000000000, 16'h0};
    tbl[1]  = '{1, 0, 3, 0, 0, 0, 0, 0, 5'd0,  9'b000000001, 16'h0};
    tbl[2]  = '{0, 0, 0, 0, 0, 0, 0, 0, 5'd0,  9'b000000000, 16'h0};
    tbl[3]  = '{1, 0, 0, 0, 0, 1, 0, 0, 5'd0,  9'b010000000, 16'h0};
    tbl[4]  = '{0, 0, 0, 0, 0, 1, 0, 0, 5'd0,  9'b100000100, 16'h0010};
    tbl[5]  = '{0, 0, 0, 0, 0, 0, 0, 0, 5'd0,  9'b100000100, 16'h0010};
    tbl[6]  = '{0, 0, 0, 1, 0, 0, 0, 0, 5'd0,  9'b100000100, 16'h0010};
    tbl[7]  = '{0, 0, 0, 0, 0, 1, 0, 0, 5'd0,  9'b000000100, 16'h0};
    tbl[8]  = '{0, 0, 0, 0, 1, 1, 1, 1, 5'd0,  9'b001000100, 16'h0};
    tbl[9]  = '{0, 0, 0, 0, 0, 1, 1, 1, 5'd16, 9'b000100100, 16'h0};
    tbl[10] = '{0, 0, 0, 0, 0, 1, 0, 1, 5'd0,  9'b000011100, 16'h0};
    tbl[11] = '{0, 0, 0, 0, 1, 1, 0, 1, 5'd0,  9'b000000100, 16'h0};
    tbl[12] = '{0, 1, 0, 0, 0, 1, 0, 0, 5'd0,  9'b010000100, 16'h0};
    tbl[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 5'd0,  9'b000000000, 16'h0};

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      start = tbl[i].st; abort = tbl[i].ab; mode = tbl[i].md;
      dram_gnt = tbl[i].gnt; dram_rvalid = tbl[i].rv;
      fifo_can_write = tbl[i].cw; fifo_can_read = tbl[i].cr;
      rf_ready = tbl[i].rdy; fifo_read_count = tbl[i].cnt;
      #1;
      chk($sformatf("vec%0d_outs", i), outs, tbl[i].exp);
      if (tbl[i].exp[8])
        chk($sformatf("vec%0d_addr", i), dram_addr, tbl[i].addr);
    end
    idle_inputs();

    run_frame(3'd0, 16'h0100, 115, 1'b0, 1'b0);
    run_frame(3'd1, 16'h0400, 115, 1'b1, 1'b1);
    run_frame(3'd0, 16'hFFFE, 4, 1'b0, 1'b0);

    // abort with a request outstanding, response 5 cycles later
    idle_inputs();
    @(negedge clk);
    start = 1; base_addr = 16'h0200; num_words = 11'd5; fifo_can_write = 1;
    @(negedge clk);
    start = 0;
    #1;
    chk("abort_first_req", dram_req, 1);
    chk("abort_first_addr", dram_addr, 16'h0200);
    dram_gnt = 1;
    @(negedge clk);
    dram_gnt = 0; abort = 1;
    #1;
    chk("abort_no_clear", fifo_clear, 0);
    chk("abort_busy", busy, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      abort = 0;
      #1;
      chk($sformatf("flush_wait%0d", k), {busy, dram_req, fifo_clear, done},
          4'b1000);
    end
    @(negedge clk);
    dram_rvalid = 1;
    #1;
    chk("flush_rvalid", {fifo_en, fifo_clear, busy, done}, 4'b0110);
    @(negedge clk);
    dram_rvalid = 0;
    #1;
    chk("flush_exit", {busy, done, dram_req}, 3'b000);

    // async reset while a request is outstanding
    idle_inputs();
    @(negedge clk);
    start = 1; mode = 3'd1; base_addr = 16'h0300; num_words = 11'd3;
    fifo_can_write = 1;
    @(negedge clk);
    start = 0;
    #1;
    chk("rst_pre_req", dram_req, 1);
    dram_gnt = 1;
    @(negedge clk);
    dram_gnt = 0;
    #1;
    chk("rst_pre_mode", fifo_mode, 3'd1);
    rst = 1;
    #1;
    chk("rst_async_outs", outs, 9'b0);
    chk("rst_async_mode", fifo_mode, 3'd0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    dram_rvalid = 1;
    #1;
    chk("rst_late_rvalid", {fifo_en, busy}, 2'b00);
    @(negedge clk);
    idle_inputs();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
